// File: rtl/bcd_countdown_timer.sv
//==============================================================================
// bcd_countdown_timer : HH:MM:SS BCD countdown with per-second prescaler,
//                       run/pause control and expiry flag.
// Revision: 1.0
//==============================================================================
`default_nettype none

module bcd_countdown_timer #(
    parameter int              TICK_W     = 26,
    parameter logic [TICK_W-1:0] TICK_COUNT = 26'd49_999_999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_bcd,
    input  logic        start,
    input  logic        stop,
    output logic [23:0] bcd,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [TICK_W-1:0] r_presc, w_presc_nxt;
    logic [23:0]       r_bcd, w_bcd_nxt, w_bcd_dec;
    logic              r_done, w_done_nxt;
    logic              r_load_err, w_err_nxt;
    logic              w_digits_ok, w_load_ok, w_borrow;
    logic              w_at_tc, w_tick, w_is_zero;

    always_comb begin
        w_digits_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (load_bcd[i*4 +: 4] > 4'd9) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    assign w_load_ok = w_digits_ok
                    && (load_bcd[15:12] <= 4'd5)
                    && (load_bcd[7:4]   <= 4'd5)
                    && ((load_bcd[23:20] < 4'd2)
                        || ((load_bcd[23:20] == 4'd2) && (load_bcd[19:16] <= 4'd3)));

    // Ripple-borrow decrement; a zero digit that lends reloads to its maximum.
    always_comb begin
        w_bcd_dec = r_bcd;
        w_borrow  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_borrow) begin
                if (r_bcd[i*4 +: 4] != 4'd0) begin
                    w_bcd_dec[i*4 +: 4] = r_bcd[i*4 +: 4] - 4'd1;
                    w_borrow            = 1'b0;
                end else begin
                    w_bcd_dec[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end
            end
        end
    end

    assign w_is_zero = (r_bcd == 24'd0);
    assign w_at_tc   = (r_presc == TICK_COUNT);
    assign w_tick    = (r_state == S_RUN) && w_at_tc && !load && !stop;

    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        if (load) begin
            w_presc_nxt = '0;
        end else if (r_state == S_RUN) begin
            if (w_at_tc) begin
                w_presc_nxt = stop ? r_presc : '0;
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
        end

        if (load) begin
            if (w_load_ok) begin
                w_bcd_nxt = load_bcd;
                if (r_state == S_EXPIRED) begin
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else if (start) begin
            if (r_state == S_IDLE && !w_is_zero) begin
                w_state_nxt = S_RUN;
                w_presc_nxt = '0;
            end else if (r_state == S_PAUSE) begin
                w_state_nxt = S_RUN;
            end
        end

        // A tick already excludes load/stop, and start is a no-op in RUN.
        if (w_tick) begin
            w_bcd_nxt = w_is_zero ? 24'd0 : w_bcd_dec;
            if (w_is_zero || (w_bcd_dec == 24'd0)) begin
                w_state_nxt = S_EXPIRED;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bcd      <= 24'd0;
            r_presc    <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bcd      <= w_bcd_nxt;
            r_presc    <= w_presc_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    assign bcd      = r_bcd;
    assign running  = (r_state == S_RUN);
    assign expired  = (r_state == S_EXPIRED);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
//==============================================================================
// tb_bcd_countdown_timer : vector table, directed corner sequences and random
//                          stimulus against a seconds-based reference model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

    localparam int TC = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [23:0] load_bcd = 24'd0;
    logic [23:0] bcd;
    logic        running, expired, done, load_err;

    bcd_countdown_timer #(
        .TICK_W     (26),
        .TICK_COUNT (26'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_bcd (load_bcd),
        .start    (start),
        .stop     (stop),
        .bcd      (bcd),
        .running  (running),
        .expired  (expired),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time as plain seconds.
    int m_secs = 0, m_st = M_IDLE, m_pre = 0;
    bit m_done = 0, m_err = 0;

    function automatic int bcd2sec(logic [23:0] v);
        int h, m, s;
        h = int'(v[23:20]) * 10 + int'(v[19:16]);
        m = int'(v[15:12]) * 10 + int'(v[11:8]);
        s = int'(v[7:4])   * 10 + int'(v[3:0]);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [23:0] sec2bcd(int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit bcd_valid(logic [23:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        if (v[15:12] > 4'd5 || v[7:4] > 4'd5) ok = 1'b0;
        if (int'(v[23:20]) * 10 + int'(v[19:16]) > 23) ok = 1'b0;
        return ok;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit ld, logic [23:0] v, bit st, bit sp);
        int  st0, pre_nxt;
        bit  tk;
        if (r) begin
            m_secs = 0; m_st = M_IDLE; m_pre = 0; m_done = 0; m_err = 0;
        end else begin
            st0    = m_st;
            m_done = 0;
            m_err  = 0;
            tk     = (st0 == M_RUN) && (m_pre == TC) && !ld && !sp;
            if (ld)                pre_nxt = 0;
            else if (st0 == M_RUN) pre_nxt = (m_pre == TC) ? (sp ? m_pre : 0) : m_pre + 1;
            else                   pre_nxt = m_pre;
            if (ld) begin
                if (bcd_valid(v)) begin
                    m_secs = bcd2sec(v);
                    if (st0 == M_EXP) m_st = M_IDLE;
                end else begin
                    m_err = 1;
                end
            end else if (sp) begin
                if (st0 == M_RUN) m_st = M_PAUSE;
            end else if (st) begin
                if (st0 == M_IDLE && m_secs != 0) begin
                    m_st = M_RUN; pre_nxt = 0;
                end else if (st0 == M_PAUSE) begin
                    m_st = M_RUN;
                end
            end
            if (tk) begin
                if (m_secs > 0) m_secs--;
                if (m_secs == 0) begin
                    m_st = M_EXP; m_done = 1;
                end
            end
            m_pre = pre_nxt;
        end
    endtask

    task automatic cyc(bit r, bit ld, logic [23:0] v, bit st, bit sp);
        rst = r; load = ld; load_bcd = v; start = st; stop = sp;
        @(posedge clk);
        model_step(r, ld, v, st, sp);
        #1;
        rst = 0; load = 0; start = 0; stop = 0;
        chk("model_bcd",      32'(bcd),      32'(sec2bcd(m_secs)));
        chk("model_running",  32'(running),  32'(m_st == M_RUN));
        chk("model_expired",  32'(expired),  32'(m_st == M_EXP));
        chk("model_done",     32'(done),     32'(m_done));
        chk("model_load_err", 32'(load_err), 32'(m_err));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 24'd0, 0, 0);
    endtask

    typedef struct {
        bit          r, ld, st, sp;
        logic [23:0] v, e_bcd;
        bit          e_run, e_exp, e_err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n, dones, sel, t;
        logic [23:0] rv;

        tbl[0]  = '{r:1, ld:1, st:0, sp:0, v:24'h24_00_00, e_bcd:24'h00_00_00, e_run:0, e_exp:0, e_err:0};
        tbl[1]  = '{r:0, ld:0, st:1, sp:0, v:24'h00_00_00, e_bcd:24'h00_00_00, e_run:0, e_exp:0, e_err:0};
        tbl[2]  = '{r:0, ld:1, st:0, sp:0, v:24'h24_00_00, e_bcd:24'h00_00_00, e_run:0, e_exp:0, e_err:1};
        tbl[3]  = '{r:0, ld:0, st:0, sp:0, v:24'h00_00_00, e_bcd:24'h00_00_00, e_run:0, e_exp:0, e_err:0};
        tbl[4]  = '{r:0, ld:1, st:0, sp:0, v:24'h00_60_00, e_bcd:24'h00_00_00, e_run:0, e_exp:0, e_err:1};
        tbl[5]  = '{r:0, ld:1, st:0, sp:0, v:24'h23_59_59, e_bcd:24'h23_59_59, e_run:0, e_exp:0, e_err:0};
        tbl[6]  = '{r:0, ld:1, st:0, sp:0, v:24'h00_00_0A, e_bcd:24'h23_59_59, e_run:0, e_exp:0, e_err:1};
        tbl[7]  = '{r:0, ld:1, st:0, sp:0, v:24'h00_59_60, e_bcd:24'h23_59_59, e_run:0, e_exp:0, e_err:1};
        tbl[8]  = '{r:0, ld:1, st:0, sp:0, v:24'h12_34_56, e_bcd:24'h12_34_56, e_run:0, e_exp:0, e_err:0};
        tbl[9]  = '{r:0, ld:0, st:1, sp:1, v:24'h00_00_00, e_bcd:24'h12_34_56, e_run:0, e_exp:0, e_err:0};
        tbl[10] = '{r:0, ld:1, st:0, sp:0, v:24'h00_01_02, e_bcd:24'h00_01_02, e_run:0, e_exp:0, e_err:0};
        tbl[11] = '{r:0, ld:0, st:0, sp:0, v:24'h00_00_00, e_bcd:24'h00_01_02, e_run:0, e_exp:0, e_err:0};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].ld, tbl[i].v, tbl[i].st, tbl[i].sp);
            chk($sformatf("tbl%0d_bcd", i),      32'(bcd),      32'(tbl[i].e_bcd));
            chk($sformatf("tbl%0d_running", i),  32'(running),  32'(tbl[i].e_run));
            chk($sformatf("tbl%0d_expired", i),  32'(expired),  32'(tbl[i].e_exp));
            chk($sformatf("tbl%0d_load_err", i), 32'(load_err), 32'(tbl[i].e_err));
        end

        // Countdown from 00:01:02 to expiry, one step every 4 cycles.
        cyc(0, 0, 24'd0, 1, 0);
        chk("start_running", 32'(running), 32'd1);
        idle(4); chk("cd_000101", 32'(bcd), 32'h00_01_01);
        idle(4); chk("cd_000100", 32'(bcd), 32'h00_01_00);
        idle(4); chk("cd_000059", 32'(bcd), 32'h00_00_59);
        n = 0; dones = 0;
        while (!expired && n < 400) begin
            idle(1);
            n++;
            if (done) dones++;
        end
        chk("expiry_reached", 32'(expired), 32'd1);
        chk("done_once",      32'(dones),   32'd1);
        chk("exp_running",    32'(running), 32'd0);
        idle(3);
        chk("exp_bcd_hold",   32'(bcd),     32'd0);
        chk("exp_done_low",   32'(done),    32'd0);
        cyc(0, 0, 24'd0, 1, 0);
        chk("exp_start_ign",  32'(running), 32'd0);

        // Borrow chains through hour digits.
        cyc(0, 1, 24'h10_00_00, 0, 0);
        chk("exp_load_idle",  32'(expired), 32'd0);
        cyc(0, 0, 24'd0, 1, 0);
        idle(4); chk("borrow_095959", 32'(bcd), 32'h09_59_59);
        cyc(0, 1, 24'h20_00_00, 0, 0);
        chk("run_load_run",   32'(running), 32'd1);
        idle(4); chk("borrow_195959", 32'(bcd), 32'h19_59_59);

        // Pause two cycles after a tick; resume finishes the partial second.
        idle(1);
        cyc(0, 0, 24'd0, 0, 1);
        chk("pause_state",    32'(running), 32'd0);
        idle(20);
        chk("pause_hold",     32'(bcd), 32'h19_59_59);
        cyc(0, 0, 24'd0, 1, 0);
        idle(1); chk("resume_early", 32'(bcd), 32'h19_59_59);
        idle(1); chk("resume_tick",  32'(bcd), 32'h19_59_58);

        // Load coinciding with a tick: load wins, prescaler restarts.
        idle(3);
        cyc(0, 1, 24'h00_01_05, 0, 0);
        chk("ld_tick_bcd",    32'(bcd), 32'h00_01_05);
        idle(3); chk("ld_tick_wait", 32'(bcd), 32'h00_01_05);
        idle(1); chk("ld_tick_next", 32'(bcd), 32'h00_01_04);

        // start+stop in RUN pauses.
        cyc(0, 0, 24'd0, 1, 1);
        chk("startstop_pause", 32'(running), 32'd0);

        // Reset mid-run, then start is ignored with bcd=0.
        cyc(0, 1, 24'h00_00_05, 0, 0);
        chk("pause_load_bcd", 32'(bcd), 32'h00_00_05);
        cyc(0, 0, 24'd0, 1, 0);
        idle(1);
        cyc(1, 0, 24'd0, 0, 0);
        chk("rst_bcd",     32'(bcd),      32'd0);
        chk("rst_running", 32'(running),  32'd0);
        chk("rst_expired", 32'(expired),  32'd0);
        chk("rst_done",    32'(done),     32'd0);
        chk("rst_err",     32'(load_err), 32'd0);
        cyc(0, 0, 24'd0, 1, 0);
        chk("rst_start_ign", 32'(running), 32'd0);

        // Random traffic checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 1) begin
                cyc(1, 0, 24'd0, 0, 0);
            end else if (sel < 6) begin
                t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 86399))
                                                : int'($urandom_range(0, 40));
                if ((m_st == M_RUN || m_st == M_PAUSE) && t == 0) t = 1;
                cyc(0, 1, sec2bcd(t), 0, 0);
            end else if (sel < 8 && (m_st == M_IDLE || m_st == M_EXP)) begin
                rv = 24'($urandom);
                if (bcd_valid(rv)) rv[3:0] = 4'hB;
                cyc(0, 1, rv, 0, 0);
            end else if (sel < 14) begin
                cyc(0, 0, 24'd0, 1, 0);
            end else if (sel < 19 && !(m_st == M_RUN && m_pre == TC)) begin
                cyc(0, 0, 24'd0, (sel == 18), 1);
            end else begin
                idle(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
